tcdm_master_adapter: RTL and testbench

Per-master front end of the TCDM interconnect. Converts a core-side valid/ready request/response interface into the interconnect's req/gnt/vld protocol. Registers each request and holds it stable until granted. Limits outstanding transactions by credits. Buffers responses, because the interconnect cannot be back-pressured. One instance sits in front of each master port.

---
 rtl/tcdm_adapter_pkg.sv | 20 ++
 rtl/tcdm_master_adapter_chk.sv | 28 ++
 rtl/tcdm_resp_fifo.sv | 67 ++++++
 rtl/tcdm_master_adapter.sv | 167 ++++++++++++++++
 tb/tb_tcdm_master_adapter.sv | 363 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tcdm_adapter_pkg.sv
// Shared types and sizing helpers for the TCDM master adapter and its response path.
// The request struct describes the default-width request word that travels to the interconnect.
package tcdm_adapter_pkg;

  localparam int unsigned DefAddrWidth = 32;
  localparam int unsigned DefDataWidth = 32;

  typedef struct packed {
    logic [DefAddrWidth-1:0]   addr;
    logic                      write;
    logic [DefDataWidth-1:0]   wdata;
    logic [DefDataWidth/8-1:0] be;
  } tcdm_req_t;

  // Width of a counter that must hold 0..max_outstanding inclusive.
  function automatic int unsigned credit_width(input int unsigned max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

endpackage

// File: rtl/tcdm_master_adapter_chk.sv
// Property checker for the adapter: credit bound, response FIFO overflow and
// request stability while waiting for a grant.
module tcdm_master_adapter_chk #(
  parameter int unsigned CntWidth       = 3,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned ReqWidth       = 1
) (
  input logic                clk_i,
  input logic                rst_i,
  input logic [CntWidth-1:0] credit,
  input logic                fifo_push,
  input logic                fifo_full,
  input logic                fifo_pop,
  input logic                req,
  input logic                gnt,
  input logic [ReqWidth-1:0] req_fields
);

  credit_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    credit <= CntWidth'(MaxOutstanding));

  no_fifo_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(fifo_push && fifo_full && !fifo_pop));

  req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (req && !gnt) |=> $stable(req_fields));

endmodule

// File: rtl/tcdm_resp_fifo.sv
// Synchronous-reset response FIFO. A push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle.
module tcdm_resp_fifo
  import tcdm_adapter_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntWidth = credit_width(Depth);

  logic [Width-1:0]    mem_r [Depth];
  logic [PtrWidth-1:0] wr_ptr_r;
  logic [PtrWidth-1:0] rd_ptr_r;
  logic [CntWidth-1:0] count_r;
  logic                push_s;
  logic                pop_s;

  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] ptr);
    return (ptr == PtrWidth'(Depth - 1)) ? {PtrWidth{1'b0}} : ptr + PtrWidth'(1);
  endfunction

  assign full_o  = (count_r == CntWidth'(Depth));
  assign empty_o = (count_r == {CntWidth{1'b0}});
  assign pop_s   = pop_i && !empty_o;
  assign push_s  = push_i && (!full_o || pop_s);
  assign data_o  = mem_r[rd_ptr_r];

  // Storage array, written on every accepted push.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r <= {PtrWidth{1'b0}};
      rd_ptr_r <= {PtrWidth{1'b0}};
      count_r  <= {CntWidth{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + CntWidth'(1);
      end else if (pop_s && !push_s) begin
        count_r <= count_r - CntWidth'(1);
      end
    end
  end

endmodule

// File: rtl/tcdm_master_adapter.sv
// Per-master TCDM front end: core valid/ready requests become held req/gnt
// transactions, credits bound outstanding work, responses are buffered.
module tcdm_master_adapter
  import tcdm_adapter_pkg::*;
#(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned BeWidth        = DataWidth / 8,
  parameter int unsigned MaxOutstanding = 4,
  parameter bit          WriteRespOn    = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 q_valid_i,
  output logic                 q_ready_o,
  input  logic [AddrWidth-1:0] q_addr_i,
  input  logic                 q_write_i,
  input  logic [DataWidth-1:0] q_wdata_i,
  input  logic [BeWidth-1:0]   q_be_i,
  output logic                 p_valid_o,
  input  logic                 p_ready_i,
  output logic [DataWidth-1:0] p_rdata_o,
  output logic                 req_o,
  output logic [AddrWidth-1:0] add_o,
  output logic                 wen_o,
  output logic [DataWidth-1:0] wdata_o,
  output logic [BeWidth-1:0]   be_o,
  input  logic                 gnt_i,
  input  logic                 vld_i,
  input  logic [DataWidth-1:0] rdata_i,
  output logic                 drop_o
);

  localparam int unsigned CntWidth = credit_width(MaxOutstanding);

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 write;
    logic [DataWidth-1:0] wdata;
    logic [BeWidth-1:0]   be;
  } req_t;

  req_t                req_r;
  logic                req_valid_r;
  logic [CntWidth-1:0] credit_r;
  logic [CntWidth-1:0] credit_d_s;
  logic [CntWidth-1:0] infl_r;
  logic [CntWidth-1:0] infl_d_s;
  logic                drop_r;
  logic                accept_s;
  logic                grant_s;
  logic                wr_release_s;
  logic                infl_inc_s;
  logic                beat_ok_s;
  logic                pop_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;

  assign grant_s      = req_valid_r && gnt_i;
  // Without write responses a store is finished once the interconnect takes it.
  assign wr_release_s = grant_s && req_r.write && !WriteRespOn;
  assign infl_inc_s   = grant_s && !wr_release_s;
  assign pop_s        = !fifo_empty_s && p_ready_i;
  assign beat_ok_s    = vld_i && (infl_r != {CntWidth{1'b0}});

  // A credit freed by this cycle's pop or write release is reusable immediately.
  assign q_ready_o = !rst_i
                  && ((credit_r < CntWidth'(MaxOutstanding)) || pop_s || wr_release_s)
                  && (!req_valid_r || gnt_i);
  assign accept_s  = q_valid_i && q_ready_o;

  assign req_o     = req_valid_r;
  assign add_o     = req_r.addr;
  assign wen_o     = req_r.write;
  assign wdata_o   = req_r.wdata;
  assign be_o      = req_r.be;
  assign p_valid_o = !fifo_empty_s;
  assign drop_o    = drop_r;

  // Next credit and in-flight counts from this cycle's events.
  always_comb begin
    credit_d_s = credit_r;
    infl_d_s   = infl_r;
    if (accept_s) begin
      credit_d_s = credit_d_s + CntWidth'(1);
    end else begin
      credit_d_s = credit_d_s;
    end
    if (pop_s) begin
      credit_d_s = credit_d_s - CntWidth'(1);
    end else begin
      credit_d_s = credit_d_s;
    end
    if (wr_release_s) begin
      credit_d_s = credit_d_s - CntWidth'(1);
    end else begin
      credit_d_s = credit_d_s;
    end
    if (infl_inc_s) begin
      infl_d_s = infl_d_s + CntWidth'(1);
    end else begin
      infl_d_s = infl_d_s;
    end
    if (beat_ok_s) begin
      infl_d_s = infl_d_s - CntWidth'(1);
    end else begin
      infl_d_s = infl_d_s;
    end
  end

  // Request register: load on core accept, release on grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_valid_r <= 1'b0;
      req_r       <= '0;
    end else if (accept_s) begin
      req_valid_r <= 1'b1;
      req_r       <= '{addr: q_addr_i, write: q_write_i, wdata: q_wdata_i, be: q_be_i};
    end else if (grant_s) begin
      req_valid_r <= 1'b0;
    end
  end

  // Credit, in-flight and drop-pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      credit_r <= {CntWidth{1'b0}};
      infl_r   <= {CntWidth{1'b0}};
      drop_r   <= 1'b0;
    end else begin
      credit_r <= credit_d_s;
      infl_r   <= infl_d_s;
      drop_r   <= vld_i && (infl_r == {CntWidth{1'b0}});
    end
  end

  tcdm_resp_fifo #(
    .Depth (MaxOutstanding),
    .Width (DataWidth)
  ) i_resp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (beat_ok_s),
    .data_i  (rdata_i),
    .pop_i   (p_ready_i),
    .data_o  (p_rdata_o),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  tcdm_master_adapter_chk #(
    .CntWidth       (CntWidth),
    .MaxOutstanding (MaxOutstanding),
    .ReqWidth       ($bits(req_t))
  ) i_chk (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .credit     (credit_r),
    .fifo_push  (beat_ok_s),
    .fifo_full  (fifo_full_s),
    .fifo_pop   (pop_s),
    .req        (req_valid_r),
    .gnt        (gnt_i),
    .req_fields (req_r)
  );

endmodule

// File: tb/tb_tcdm_master_adapter.sv
// Self-checking bench: directed scenarios plus a randomized run against a
// queue/memory reference model of the core-visible behaviour.
module tb_tcdm_master_adapter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  logic        q_valid_i, q_ready_o, q_write_i, p_valid_o, p_ready_i;
  logic [31:0] q_addr_i, q_wdata_i, p_rdata_o, add_o, wdata_o, rdata_i;
  logic [3:0]  q_be_i, be_o;
  logic        req_o, wen_o, gnt_i, vld_i, drop_o;

  logic        n_q_valid, n_q_ready, n_q_write, n_p_valid, n_p_ready;
  logic [31:0] n_q_addr, n_q_wdata, n_p_rdata, n_add, n_wdata, n_rdata;
  logic [3:0]  n_q_be, n_be;
  logic        n_req, n_wen, n_gnt, n_vld, n_drop;

  tcdm_master_adapter #(.AddrWidth(32), .DataWidth(32), .BeWidth(4),
                        .MaxOutstanding(4), .WriteRespOn(1'b1)) dut (
    .clk_i(clk), .rst_i(rst_i), .q_valid_i(q_valid_i), .q_ready_o(q_ready_o),
    .q_addr_i(q_addr_i), .q_write_i(q_write_i), .q_wdata_i(q_wdata_i), .q_be_i(q_be_i),
    .p_valid_o(p_valid_o), .p_ready_i(p_ready_i), .p_rdata_o(p_rdata_o),
    .req_o(req_o), .add_o(add_o), .wen_o(wen_o), .wdata_o(wdata_o), .be_o(be_o),
    .gnt_i(gnt_i), .vld_i(vld_i), .rdata_i(rdata_i), .drop_o(drop_o));

  tcdm_master_adapter #(.AddrWidth(32), .DataWidth(32), .BeWidth(4),
                        .MaxOutstanding(4), .WriteRespOn(1'b0)) dut_nw (
    .clk_i(clk), .rst_i(rst_i), .q_valid_i(n_q_valid), .q_ready_o(n_q_ready),
    .q_addr_i(n_q_addr), .q_write_i(n_q_write), .q_wdata_i(n_q_wdata), .q_be_i(n_q_be),
    .p_valid_o(n_p_valid), .p_ready_i(n_p_ready), .p_rdata_o(n_p_rdata),
    .req_o(n_req), .add_o(n_add), .wen_o(n_wen), .wdata_o(n_wdata), .be_o(n_be),
    .gnt_i(n_gnt), .vld_i(n_vld), .rdata_i(n_rdata), .drop_o(n_drop));

  int errors = 0;
  int checks = 0;

  typedef struct { bit is_write; logic [31:0] data; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] got_q[$];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] resp_mem  [logic [31:0]];
  bit          pipe_v [4];
  logic [31:0] pipe_d [4];
  int          mem_lat = 1;

  logic        s_qr, s_req, s_wen, s_pv, s_drop, s_acc, s_grt, s_pop;
  logic [31:0] s_add, s_wdata, s_pd;
  logic [3:0]  s_be;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] resp_rd(input logic [31:0] a);
    return resp_mem.exists(a) ? resp_mem[a] : init_word(a);
  endfunction

  // One cycle: sample at negedge, update model and memory responder, drive after posedge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    s_qr = q_ready_o; s_req = req_o; s_add = add_o; s_wen = wen_o; s_wdata = wdata_o;
    s_be = be_o; s_pv = p_valid_o; s_pd = p_rdata_o; s_drop = drop_o;
    s_acc = q_valid_i && q_ready_o;
    s_grt = req_o && gnt_i;
    s_pop = p_valid_o && p_ready_i;
    if (rst_i) begin
      exp_q.delete();
      got_q.delete();
    end else begin
      if (s_acc) begin
        if (q_write_i) begin
          model_mem[q_addr_i] = merge(model_rd(q_addr_i), q_wdata_i, q_be_i);
          e.is_write = 1'b1; e.data = 32'h0;
        end else begin
          e.is_write = 1'b0; e.data = model_rd(q_addr_i);
        end
        exp_q.push_back(e);
      end
      if (s_pop) got_q.push_back(p_rdata_o);
    end
    if (s_grt) begin
      pipe_v[mem_lat-1] = 1'b1;
      if (wen_o) begin
        resp_mem[add_o] = merge(resp_rd(add_o), wdata_o, be_o);
        pipe_d[mem_lat-1] = $urandom;
      end else begin
        pipe_d[mem_lat-1] = resp_rd(add_o);
      end
    end
    @(posedge clk);
    #1;
    vld_i = pipe_v[0];
    rdata_i = pipe_d[0];
    for (int i = 0; i < 3; i++) begin
      pipe_v[i] = pipe_v[i+1];
      pipe_d[i] = pipe_d[i+1];
    end
    pipe_v[3] = 1'b0;
  endtask

  task automatic drain();
    q_valid_i = 1'b0; gnt_i = 1'b1; p_ready_i = 1'b1;
    for (int i = 0; i < 300 && got_q.size() < exp_q.size(); i++) tick();
    for (int i = 0; i < 5; i++) tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    checks++;
    if (s_qr !== 1'b0) begin errors++; $display("FAIL reset_qready_low: got %0b want 0", s_qr); end
    rst_i = 1'b0;
    tick();
    checks++;
    if ({s_qr, s_req, s_pv, s_drop} !== 4'b1000) begin
      errors++; $display("FAIL reset_values: qready/req/pvalid/drop got %b want 1000", {s_qr, s_req, s_pv, s_drop});
    end
  endtask

  task automatic test_single_load();
    model_mem[32'h40] = 32'hDEADBEEF;
    resp_mem[32'h40]  = 32'hDEADBEEF;
    mem_lat = 1;
    q_valid_i = 1'b1; q_addr_i = 32'h40; q_write_i = 1'b0; gnt_i = 1'b1; p_ready_i = 1'b0;
    tick();
    checks++;
    if (s_acc !== 1'b1) begin errors++; $display("FAIL load_accept: got %0b want 1", s_acc); end
    q_valid_i = 1'b0;
    tick();
    checks++;
    if ({s_req, s_wen, s_add} !== {1'b1, 1'b0, 32'h40}) begin
      errors++; $display("FAIL load_req_cycle1: req/wen/add got %0b/%0b/%h want 1/0/00000040", s_req, s_wen, s_add);
    end
    tick();
    checks++;
    if (s_pv !== 1'b0) begin errors++; $display("FAIL load_pvalid_cycle2: got %0b want 0", s_pv); end
    tick();
    checks++;
    if ({s_pv, s_pd} !== {1'b1, 32'hDEADBEEF}) begin
      errors++; $display("FAIL load_resp_cycle3: pvalid/rdata got %0b/%h want 1/deadbeef", s_pv, s_pd);
    end
    p_ready_i = 1'b1;
    tick();
    tick();
    checks++;
    if ({s_pv, s_qr} !== 2'b01 || got_q.size() != 1) begin
      errors++; $display("FAIL load_done: pvalid/qready got %0b/%0b pops %0d want 0/1 pops 1", s_pv, s_qr, got_q.size());
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_store_stall();
    logic [31:0] wd;
    wd = $urandom;
    q_valid_i = 1'b1; q_write_i = 1'b1; q_addr_i = 32'h80; q_wdata_i = wd; q_be_i = 4'b0110;
    gnt_i = 1'b0; p_ready_i = 1'b0;
    tick();
    checks++;
    if (s_acc !== 1'b1) begin errors++; $display("FAIL store_accept: got %0b want 1", s_acc); end
    q_valid_i = 1'b0; q_wdata_i = ~wd; q_addr_i = 32'hFFF0; q_be_i = 4'b1001;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({s_req, s_wen, s_add, s_wdata, s_be, s_qr} !== {1'b1, 1'b1, 32'h80, wd, 4'b0110, 1'b0}) begin
        errors++;
        $display("FAIL store_hold[%0d]: req/wen/add/wdata/be/qready got %0b/%0b/%h/%h/%b/%0b want 1/1/00000080/%h/0110/0",
                 i, s_req, s_wen, s_add, s_wdata, s_be, s_qr, wd);
      end
    end
    gnt_i = 1'b1;
    tick();
    checks++;
    if ({s_qr, s_grt} !== 2'b11) begin
      errors++; $display("FAIL store_grant_cycle: qready/grant got %0b/%0b want 1/1", s_qr, s_grt);
    end
    drain();
    checks++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      errors++; $display("FAIL store_response: got %0d responses want 1", got_q.size());
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_credit_limit();
    mem_lat = 1;
    gnt_i = 1'b1; p_ready_i = 1'b0; q_write_i = 1'b0; q_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q_addr_i = 32'h200 + 32'(i * 4);
      tick();
      checks++;
      if (s_acc !== 1'b1) begin errors++; $display("FAIL credit_accept[%0d]: got %0b want 1", i, s_acc); end
    end
    q_addr_i = 32'h210;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (s_qr !== 1'b0) begin errors++; $display("FAIL credit_stall[%0d]: qready got %0b want 0", i, s_qr); end
    end
    checks++;
    if (s_pv !== 1'b1) begin errors++; $display("FAIL credit_fifo_holds: pvalid got %0b want 1", s_pv); end
    p_ready_i = 1'b1;
    tick();
    checks++;
    if ({s_pop, s_qr, s_acc} !== 3'b111) begin
      errors++; $display("FAIL credit_pop_frees: pop/qready/accept got %b want 111", {s_pop, s_qr, s_acc});
    end
    q_valid_i = 1'b0; p_ready_i = 1'b0;
    tick();
    q_valid_i = 1'b1; q_addr_i = 32'h214;
    tick();
    checks++;
    if (s_qr !== 1'b0) begin errors++; $display("FAIL credit_full_again: qready got %0b want 0", s_qr); end
    drain();
    checks++;
    if (got_q.size() != 5 || exp_q.size() != 5) begin
      errors++; $display("FAIL credit_count: got %0d responses want 5 (expected %0d)", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < 5 && i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i].data) begin
        errors++; $display("FAIL credit_data[%0d]: got %h want %h", i, got_q[i], exp_q[i].data);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_no_write_resp();
    int accepted;
    accepted = 0;
    n_gnt = 1'b1; n_p_ready = 1'b0; n_vld = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_q_valid = (i < 8); n_q_write = 1'b1; n_q_addr = 32'(i * 4);
      n_q_wdata = $urandom; n_q_be = 4'hF;
      @(negedge clk);
      if (n_q_valid && n_q_ready) accepted++;
      if (i < 8) begin
        checks++;
        if (n_q_ready !== 1'b1) begin errors++; $display("FAIL nw_qready[%0d]: got %0b want 1", i, n_q_ready); end
      end
      if (i > 0 && i < 9) begin
        checks++;
        if ({n_req, n_wen, n_add} !== {1'b1, 1'b1, 32'((i - 1) * 4)}) begin
          errors++; $display("FAIL nw_issue[%0d]: req/wen/add got %0b/%0b/%h want 1/1/%h", i, n_req, n_wen, n_add, 32'((i - 1) * 4));
        end
      end
      checks++;
      if (n_p_valid !== 1'b0) begin errors++; $display("FAIL nw_pvalid[%0d]: got %0b want 0", i, n_p_valid); end
      @(posedge clk);
      #1;
    end
    n_q_valid = 1'b0;
    checks++;
    if (accepted != 8) begin errors++; $display("FAIL nw_accepted: got %0d want 8", accepted); end
  endtask

  task automatic test_reset_mid_flight();
    int drops;
    logic pv_seen;
    mem_lat = 2;
    q_valid_i = 1'b1; q_write_i = 1'b0; q_addr_i = 32'h100; gnt_i = 1'b1; p_ready_i = 1'b1;
    tick();
    q_valid_i = 1'b0;
    tick();
    checks++;
    if (s_grt !== 1'b1) begin errors++; $display("FAIL rst_mid_grant: got %0b want 1", s_grt); end
    rst_i = 1'b1;
    tick();
    checks++;
    if (s_qr !== 1'b0) begin errors++; $display("FAIL rst_mid_qready: got %0b want 0", s_qr); end
    rst_i = 1'b0;
    drops = 0; pv_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (s_drop) drops++;
      if (s_pv) pv_seen = 1'b1;
    end
    checks++;
    if (drops != 1) begin errors++; $display("FAIL rst_mid_drop_pulses: got %0d want 1", drops); end
    checks++;
    if (pv_seen !== 1'b0) begin errors++; $display("FAIL rst_mid_pvalid: got %0b want 0", pv_seen); end
    mem_lat = 1;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random();
    int drops, accepted, shown;
    for (int phase = 0; phase < 2; phase++) begin
      mem_lat = (phase == 0) ? 1 : 3;
      drops = 0; accepted = 0; shown = 0;
      q_valid_i = 1'b0; s_acc = 1'b0;
      for (int cyc = 0; cyc < 5000; cyc++) begin
        if (!q_valid_i || s_acc) begin
          q_valid_i = ($urandom_range(0, 3) != 0);
          q_addr_i  = 32'h300 + 32'($urandom_range(0, 7) * 4);
          q_write_i = $urandom_range(0, 2) == 0;
          q_wdata_i = $urandom;
          q_be_i    = 4'($urandom_range(1, 15));
        end
        gnt_i     = ($urandom_range(0, 9) < 7);
        p_ready_i = ($urandom_range(0, 9) < 6);
        tick();
        if (s_acc) accepted++;
        if (s_drop) drops++;
      end
      drain();
      checks++;
      if (accepted < 500) begin errors++; $display("FAIL rnd_progress[%0d]: accepted %0d want >=500", phase, accepted); end
      checks++;
      if (drops != 0) begin errors++; $display("FAIL rnd_drops[%0d]: got %0d want 0", phase, drops); end
      checks++;
      if (got_q.size() != exp_q.size()) begin
        errors++; $display("FAIL rnd_count[%0d]: got %0d responses want %0d", phase, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        if (!exp_q[i].is_write) begin
          checks++;
          if (got_q[i] !== exp_q[i].data) begin
            errors++;
            if (shown < 10) begin
              shown++;
              $display("FAIL rnd_data[%0d][%0d]: got %h want %h", phase, i, got_q[i], exp_q[i].data);
            end
          end
        end
      end
      exp_q.delete(); got_q.delete();
    end
  endtask

  initial begin
    rst_i = 1'b1;
    q_valid_i = 1'b0; q_addr_i = 32'h0; q_write_i = 1'b0; q_wdata_i = 32'h0; q_be_i = 4'h0;
    p_ready_i = 1'b0; gnt_i = 1'b0; vld_i = 1'b0; rdata_i = 32'h0;
    n_q_valid = 1'b0; n_q_addr = 32'h0; n_q_write = 1'b0; n_q_wdata = 32'h0; n_q_be = 4'h0;
    n_p_ready = 1'b0; n_gnt = 1'b0; n_vld = 1'b0; n_rdata = 32'h0;
    for (int i = 0; i < 4; i++) begin pipe_v[i] = 1'b0; pipe_d[i] = 32'h0; end
    test_reset();
    test_single_load();
    test_store_stall();
    test_credit_limit();
    test_no_write_resp();
    test_reset_mid_flight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
